// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ write-back sources.
// Optional WB_BYPASS_EN adds forwarding outputs and ties hazard1/hazard2 low.
module regfile_wb_arbiter #(
  parameter int Nbits = 64,
  parameter int NREQ  = 3,
  parameter int CNTW  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*5-1:0]       req_addr,
  input  logic [NREQ*Nbits-1:0]   req_data,
  input  logic                    hold,
  output logic                    rf_we,
  output logic [4:0]              rf_w_reg,
  output logic [Nbits-1:0]        rf_w_data,
  input  logic [4:0]              rd_addr1,
  input  logic [4:0]              rd_addr2,
  output logic                    hazard1,
  output logic                    hazard2,
`ifdef WB_BYPASS_EN
  output logic                    byp1_valid,
  output logic                    byp2_valid,
  output logic [Nbits-1:0]        byp1_data,
  output logic [Nbits-1:0]        byp2_data,
`endif
  output logic [CNTW-1:0]         wr_count
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    ptr_next;
  logic [PW:0]      cand;
  logic             found;
  logic [4:0]       sel_addr;
  logic [Nbits-1:0] sel_data;
  logic             raw1;
  logic             raw2;

  // Scan requesters starting at rr_ptr, wrapping modulo NREQ; first valid one wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!hold && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = {1'b0, rr_ptr} + (PW+1)'(k);
        if (cand >= (PW+1)'(NREQ))
          cand = cand - (PW+1)'(NREQ);
        if (!found && req_valid[cand[PW-1:0]]) begin
          found     = 1'b1;
          grant_idx = cand[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found)
      req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == PW'(i)) begin
        sel_addr = req_addr[i*5 +: 5];
        sel_data = req_data[i*Nbits +: Nbits];
      end
    end
  end

  assign ptr_next = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + 1'b1;

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      rf_we     <= 1'b0;
      rf_w_reg  <= '0;
      rf_w_data <= '0;
    end else if (found) begin
      rr_ptr    <= ptr_next;
      rf_w_reg  <= sel_addr;
      rf_w_data <= sel_data;
      rf_we     <= (sel_addr != 5'd0);
    end else begin
      rf_we     <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wr_count <= '0;
    else if (rf_we && (wr_count != '1))
      wr_count <= wr_count + 1'b1;
  end

  assign raw1 = rf_we && (rf_w_reg == rd_addr1) && (rd_addr1 != 5'd0);
  assign raw2 = rf_we && (rf_w_reg == rd_addr2) && (rd_addr2 != 5'd0);

`ifdef WB_BYPASS_EN
  assign byp1_valid = raw1;
  assign byp2_valid = raw2;
  assign byp1_data  = rf_w_data;
  assign byp2_data  = rf_w_data;
  assign hazard1    = 1'b0;
  assign hazard2    = 1'b0;
`else
  assign hazard1    = raw1;
  assign hazard2    = raw2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a behavioural model; a second CNTW=2 instance exercises counter saturation.
module tb_regfile_wb_arbiter;

  localparam int NB   = 64;
  localparam int NR   = 3;
  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*5-1:0]   req_addr;
  logic [NR*NB-1:0]  req_data;
  logic              hold;
  logic              rf_we;
  logic [4:0]        rf_w_reg;
  logic [NB-1:0]     rf_w_data;
  logic [4:0]        rd_addr1;
  logic [4:0]        rd_addr2;
  logic              hazard1;
  logic              hazard2;
  logic [CW-1:0]     wr_count;
`ifdef WB_BYPASS_EN
  logic              byp1_valid, byp2_valid;
  logic [NB-1:0]     byp1_data, byp2_data;
  logic              s_b1v, s_b2v;
  logic [7:0]        s_b1d, s_b2d;
`endif

  logic [1:0]        s_valid;
  logic [1:0]        s_ready;
  logic [9:0]        s_addr;
  logic [15:0]       s_data;
  logic              s_we;
  logic [4:0]        s_reg;
  logic [7:0]        s_wdata;
  logic              s_h1, s_h2;
  logic [1:0]        s_cnt;

  regfile_wb_arbiter #(.Nbits(NB), .NREQ(NR), .CNTW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .hold(hold),
    .rf_we(rf_we), .rf_w_reg(rf_w_reg), .rf_w_data(rf_w_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .hazard1(hazard1), .hazard2(hazard2),
`ifdef WB_BYPASS_EN
    .byp1_valid(byp1_valid), .byp2_valid(byp2_valid),
    .byp1_data(byp1_data), .byp2_data(byp2_data),
`endif
    .wr_count(wr_count)
  );

  regfile_wb_arbiter #(.Nbits(8), .NREQ(2), .CNTW(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req_valid(s_valid), .req_ready(s_ready),
    .req_addr(s_addr), .req_data(s_data), .hold(1'b0),
    .rf_we(s_we), .rf_w_reg(s_reg), .rf_w_data(s_wdata),
    .rd_addr1(5'd0), .rd_addr2(5'd0),
    .hazard1(s_h1), .hazard2(s_h2),
`ifdef WB_BYPASS_EN
    .byp1_valid(s_b1v), .byp2_valid(s_b2v),
    .byp1_data(s_b1d), .byp2_data(s_b2d),
`endif
    .wr_count(s_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the registered write port and arbitration pointer
  int          m_ptr;
  bit          m_we;
  logic [4:0]  m_reg;
  logic [NB-1:0] m_data;
  int          m_cnt;

  function automatic int exp_grant();
    if (hold || rst) return -1;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    logic [NR-1:0] r;
    int g;
    r = '0;
    g = exp_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic bit exp_raw(input logic [4:0] a);
    return m_we && (m_reg == a) && (a != 5'd0);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_we = 0; m_reg = '0; m_data = '0; m_cnt = 0;
  endtask

  task automatic tick();
    int g;
    g = exp_grant();
    if (m_we && m_cnt < CMAX) m_cnt++;
    if (g >= 0) begin
      m_ptr  = (g + 1) % NR;
      m_reg  = req_addr[g*5 +: 5];
      m_data = req_data[g*NB +: NB];
      m_we   = (m_reg != 5'd0);
    end else begin
      m_we = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [NB-1:0] d);
    req_valid[i]       = v;
    req_addr[i*5 +: 5] = a;
    req_data[i*NB +: NB] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; req_valid = '1;
    req_addr = '1; req_data = '1; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    s_valid = '0; s_addr = '0; s_data = '0;
    #2;
    checks += 7;
    if (rf_we !== 1'b0)      begin errors++; $display("[TB] FAIL reset_we got %0b want 0", rf_we); end
    if (rf_w_reg !== 5'd0)   begin errors++; $display("[TB] FAIL reset_wreg got %0d want 0", rf_w_reg); end
    if (rf_w_data !== '0)    begin errors++; $display("[TB] FAIL reset_wdata got %h want 0", rf_w_data); end
    if (wr_count !== '0)     begin errors++; $display("[TB] FAIL reset_count got %0d want 0", wr_count); end
    if (req_ready !== '0)    begin errors++; $display("[TB] FAIL reset_ready got %b want 000", req_ready); end
    if (hazard1 !== 1'b0 || hazard2 !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_hazard got %b%b want 00", hazard1, hazard2); end
    if (s_cnt !== 2'd0)      begin errors++; $display("[TB] FAIL reset_sat_count got %0d want 0", s_cnt); end
    req_valid = '0; req_addr = '0; req_data = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] onehot;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 5'(5 + i), NB'(64'h100 + i));
    #1;
    for (int k = 0; k < NR; k++) begin
      onehot = NR'(1) << k;
      checks += 2;
      if (req_ready !== onehot)      begin errors++; $display("[TB] FAIL rr_ready%0d got %b want %b", k, req_ready, onehot); end
      if (req_ready !== exp_ready()) begin errors++; $display("[TB] FAIL rr_model%0d got %b want %b", k, req_ready, exp_ready()); end
      tick();
      checks += 3;
      if (rf_we !== 1'b1)            begin errors++; $display("[TB] FAIL rr_we%0d got %0b want 1", k, rf_we); end
      if (rf_w_reg !== 5'(5 + k))    begin errors++; $display("[TB] FAIL rr_wreg%0d got %0d want %0d", k, rf_w_reg, 5 + k); end
      if (rf_w_data !== m_data)      begin errors++; $display("[TB] FAIL rr_wdata%0d got %h want %h", k, rf_w_data, m_data); end
    end
    req_valid = '0;
    tick();
    checks += 2;
    if (wr_count !== CW'(3))         begin errors++; $display("[TB] FAIL rr_count got %0d want 3", wr_count); end
    if (rf_we !== 1'b0)              begin errors++; $display("[TB] FAIL rr_idle_we got %0b want 0", rf_we); end
  endtask

  task automatic test_x0();
    set_req(0, 1'b1, 5'd0, NB'(64'hFF));
    #1;
    checks++;
    if (req_ready !== 3'b001) begin errors++; $display("[TB] FAIL x0_ready got %b want 001", req_ready); end
    tick();
    req_valid = '0;
    checks += 2;
    if (rf_we !== 1'b0)          begin errors++; $display("[TB] FAIL x0_we got %0b want 0", rf_we); end
    if (wr_count !== CW'(m_cnt)) begin errors++; $display("[TB] FAIL x0_count got %0d want %0d", wr_count, m_cnt); end
    tick();
    checks++;
    if (wr_count !== CW'(3))     begin errors++; $display("[TB] FAIL x0_count_after got %0d want 3", wr_count); end
  endtask

  task automatic test_hold();
    logic [NB-1:0] d;
    d = {$urandom, $urandom};
    hold = 1'b1;
    set_req(1, 1'b1, 5'd9, d);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (req_ready !== '0) begin errors++; $display("[TB] FAIL hold_ready%0d got %b want 000", c, req_ready); end
      tick();
      checks++;
      if (rf_we !== 1'b0)   begin errors++; $display("[TB] FAIL hold_we%0d got %0b want 0", c, rf_we); end
    end
    hold = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin errors++; $display("[TB] FAIL hold_release_ready got %b want 010", req_ready); end
    tick();
    req_valid = '0;
    checks += 3;
    if (rf_we !== 1'b1)     begin errors++; $display("[TB] FAIL hold_we got %0b want 1", rf_we); end
    if (rf_w_reg !== 5'd9)  begin errors++; $display("[TB] FAIL hold_wreg got %0d want 9", rf_w_reg); end
    if (rf_w_data !== d)    begin errors++; $display("[TB] FAIL hold_wdata got %h want %h", rf_w_data, d); end
  endtask

  task automatic test_hazard();
    set_req(2, 1'b1, 5'd6, NB'(64'h2A));
    #1;
    checks++;
    if (req_ready !== 3'b100) begin errors++; $display("[TB] FAIL haz_ready got %b want 100", req_ready); end
    tick();
    req_valid = '0;
    rd_addr1 = 5'd6; rd_addr2 = 5'd0;
    #1;
`ifdef WB_BYPASS_EN
    checks += 4;
    if (hazard1 !== 1'b0)       begin errors++; $display("[TB] FAIL haz_h1 got %0b want 0", hazard1); end
    if (byp1_valid !== 1'b1)    begin errors++; $display("[TB] FAIL haz_byp1v got %0b want 1", byp1_valid); end
    if (byp1_data !== NB'(64'h2A)) begin errors++; $display("[TB] FAIL haz_byp1d got %h want 2a", byp1_data); end
    if (byp2_valid !== 1'b0)    begin errors++; $display("[TB] FAIL haz_byp2v got %0b want 0", byp2_valid); end
`else
    checks += 2;
    if (hazard1 !== 1'b1)       begin errors++; $display("[TB] FAIL haz_h1 got %0b want 1", hazard1); end
    if (hazard2 !== 1'b0)       begin errors++; $display("[TB] FAIL haz_h2 got %0b want 0", hazard2); end
`endif
    rd_addr2 = 5'd6;
    #1;
`ifdef WB_BYPASS_EN
    checks++;
    if (byp2_valid !== 1'b1)    begin errors++; $display("[TB] FAIL haz_both_byp2v got %0b want 1", byp2_valid); end
`else
    checks++;
    if (hazard2 !== 1'b1)       begin errors++; $display("[TB] FAIL haz_both_h2 got %0b want 1", hazard2); end
`endif
    tick();
    checks++;
`ifdef WB_BYPASS_EN
    if (byp1_valid !== 1'b0)    begin errors++; $display("[TB] FAIL haz_clear got %0b want 0", byp1_valid); end
`else
    if (hazard1 !== 1'b0)       begin errors++; $display("[TB] FAIL haz_clear got %0b want 0", hazard1); end
`endif
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
  endtask

  task automatic test_reset_mid_write();
    set_req(0, 1'b1, 5'd12, {$urandom, $urandom});
    tick();
    req_valid = '0;
    checks++;
    if (rf_we !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_we got %0b want 1", rf_we); end
    #2;
    rst = 1'b1;
    #1;
    checks += 4;
    if (rf_we !== 1'b0)    begin errors++; $display("[TB] FAIL midrst_we got %0b want 0", rf_we); end
    if (rf_w_reg !== 5'd0) begin errors++; $display("[TB] FAIL midrst_wreg got %0d want 0", rf_w_reg); end
    if (wr_count !== '0)   begin errors++; $display("[TB] FAIL midrst_count got %0d want 0", wr_count); end
    if (rf_w_data !== '0)  begin errors++; $display("[TB] FAIL midrst_wdata got %h want 0", rf_w_data); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_saturate();
    logic [1:0] expc [5];
    expc = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    s_valid = 2'b01; s_addr = 10'd3; s_data = 16'h0005;
    for (int n = 1; n <= 6; n++) begin
      if (n == 6) s_valid = '0;
      tick();
      if (n <= 5) begin
        checks++;
        if (s_we !== 1'b1) begin errors++; $display("[TB] FAIL sat_we%0d got %0b want 1", n, s_we); end
      end
      if (n >= 2) begin
        checks++;
        if (s_cnt !== expc[n-2]) begin errors++; $display("[TB] FAIL sat_count%0d got %0d want %0d", n, s_cnt, expc[n-2]); end
      end
    end
  endtask

  task automatic test_random();
    int g_last;
    g_last = -1;
    for (int c = 0; c < 400; c++) begin
      hold = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!(req_valid[i] && i != g_last))
          set_req(i, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                  {$urandom, $urandom});
      end
      rd_addr1 = ($urandom_range(0, 1) == 1) ? m_reg : 5'($urandom_range(0, 31));
      rd_addr2 = ($urandom_range(0, 1) == 1) ? m_reg : 5'($urandom_range(0, 31));
      #1;
      checks += 6;
      if (req_ready !== exp_ready()) begin errors++; $display("[TB] FAIL rnd_ready c%0d got %b want %b", c, req_ready, exp_ready()); end
      if (rf_we !== m_we)            begin errors++; $display("[TB] FAIL rnd_we c%0d got %0b want %0b", c, rf_we, m_we); end
      if (rf_w_reg !== m_reg)        begin errors++; $display("[TB] FAIL rnd_wreg c%0d got %0d want %0d", c, rf_w_reg, m_reg); end
      if (rf_w_data !== m_data)      begin errors++; $display("[TB] FAIL rnd_wdata c%0d got %h want %h", c, rf_w_data, m_data); end
      if (wr_count !== CW'(m_cnt))   begin errors++; $display("[TB] FAIL rnd_count c%0d got %0d want %0d", c, wr_count, m_cnt); end
`ifdef WB_BYPASS_EN
      if (byp1_valid !== exp_raw(rd_addr1) || byp2_valid !== exp_raw(rd_addr2) || hazard1 !== 1'b0 || hazard2 !== 1'b0)
        begin errors++; $display("[TB] FAIL rnd_bypass c%0d got %b%b want %b%b", c, byp1_valid, byp2_valid, exp_raw(rd_addr1), exp_raw(rd_addr2)); end
`else
      if (hazard1 !== exp_raw(rd_addr1) || hazard2 !== exp_raw(rd_addr2))
        begin errors++; $display("[TB] FAIL rnd_hazard c%0d got %b%b want %b%b", c, hazard1, hazard2, exp_raw(rd_addr1), exp_raw(rd_addr2)); end
`endif
      g_last = exp_grant();
      tick();
    end
    req_valid = '0; hold = 1'b0;
  endtask

  initial begin
    test_reset();
    tick();
    test_round_robin();
    test_x0();
    test_hold();
    test_hazard();
    test_reset_mid_write();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
